// File: rtl/ov_cap_pkg.sv
// Shared definitions for the camera capture / overlay stage.
//   GREEN, RED, BLUE : RGB565 overlay colours (marker, target box, threshold hit)
//   mode_e           : overlay mode encoding driven on the mode input
//   state_e          : frame-sync state machine states
package ov_cap_pkg;

  localparam logic [15:0] GREEN = 16'h07E0;
  localparam logic [15:0] RED   = 16'hF800;
  localparam logic [15:0] BLUE  = 16'h001F;

  typedef enum logic [1:0] {
    ModeRaw        = 2'd0,
    ModeOverlay    = 2'd1,
    ModeThresh     = 2'd2,
    ModeOverlayAlt = 2'd3  // behaves exactly like ModeOverlay
  } mode_e;

  typedef enum logic [1:0] {
    StWaitSync = 2'd0,
    StBlank    = 2'd1,
    StActive   = 2'd2
  } state_e;

endpackage

// File: rtl/ov_overlay_mux.sv
// Combinational colour decision for one captured pixel.
// Ports:
//   i_x, i_y        : pixel coordinate (CW bits)
//   i_mode          : frame-latched overlay mode
//   i_avg_x/y       : frame-latched laser centroid
//   i_target_x/y    : frame-latched target box top-left corner
//   i_disappear     : frame-latched target hide flag
//   i_raw           : assembled RGB565 pixel
//   o_pix           : pixel to write (overlay colour or raw)
module ov_overlay_mux
  import ov_cap_pkg::*;
#(
  parameter int unsigned CW       = 10,
  parameter int unsigned MARK_R   = 2,
  parameter int unsigned TGT_SIZE = 15,
  parameter int unsigned THRESH   = 12
) (
  input  logic [CW-1:0] i_x,
  input  logic [CW-1:0] i_y,
  input  mode_e         i_mode,
  input  logic [CW-1:0] i_avg_x,
  input  logic [CW-1:0] i_avg_y,
  input  logic [CW-1:0] i_target_x,
  input  logic [CW-1:0] i_target_y,
  input  logic          i_disappear,
  input  logic [15:0]   i_raw,
  output logic [15:0]   o_pix
);

  // One extra bit so target + TGT_SIZE can never wrap.
  logic [CW:0] w_x, w_y, w_ax, w_ay, w_tx, w_ty;
  logic [CW:0] w_dx, w_dy;
  logic        w_marker, w_in_box, w_hot;

  assign w_x  = {1'b0, i_x};
  assign w_y  = {1'b0, i_y};
  assign w_ax = {1'b0, i_avg_x};
  assign w_ay = {1'b0, i_avg_y};
  assign w_tx = {1'b0, i_target_x};
  assign w_ty = {1'b0, i_target_y};

  assign w_dx = (w_x >= w_ax) ? (w_x - w_ax) : (w_ax - w_x);
  assign w_dy = (w_y >= w_ay) ? (w_y - w_ay) : (w_ay - w_y);

  assign w_marker = (w_dx <= (CW+1)'(MARK_R)) && (w_dy <= (CW+1)'(MARK_R));

  assign w_in_box = !i_disappear &&
                    (w_x >= w_tx) && (w_x < w_tx + (CW+1)'(TGT_SIZE)) &&
                    (w_y >= w_ty) && (w_y < w_ty + (CW+1)'(TGT_SIZE));

  // red is pix[15:11]; its upper four bits are compared
  assign w_hot = i_raw[15:12] > 4'(THRESH);

  always_comb begin
    o_pix = i_raw;
    if (i_mode != ModeRaw) begin
      if (w_marker) begin
        o_pix = GREEN;
      end else if (w_in_box) begin
        o_pix = RED;
      end else if ((i_mode == ModeThresh) && w_hot) begin
        o_pix = BLUE;
      end
    end
  end

endmodule

// File: rtl/ov_capture_overlay.sv
// OV7670 capture stage: assembles RGB565 pixels from the camera byte stream,
// applies the marker / target / threshold overlays and writes the frame buffer.
// Ports:
//   i_pclk, i_resetn      : pixel clock, asynchronous active-low reset
//   i_vsync, i_href, i_d  : camera sync, line valid and data byte (high byte first)
//   i_mode                : 0 raw, 1/3 overlay, 2 overlay + red threshold
//   i_avg_x, i_avg_y      : laser centroid (latched at vsync falling)
//   i_target_x/y          : target box corner (latched at vsync falling)
//   i_disappear           : hide target box (latched at vsync falling)
//   o_addr, o_dout, o_we  : frame-buffer write port, one write per pixel
//   o_frame_done          : one-cycle pulse when a frame with lines ends
//   o_line_err            : sticky per frame, some line ended with x != H_RES
module ov_capture_overlay
  import ov_cap_pkg::*;
#(
  parameter int unsigned H_RES    = 320,
  parameter int unsigned V_RES    = 240,
  parameter int unsigned AW       = 17,
  parameter int unsigned CW       = 10,
  parameter int unsigned MARK_R   = 2,
  parameter int unsigned TGT_SIZE = 15,
  parameter int unsigned THRESH   = 12
) (
  input  logic          i_pclk,
  input  logic          i_resetn,
  input  logic          i_vsync,
  input  logic          i_href,
  input  logic [7:0]    i_d,
  input  logic [1:0]    i_mode,
  input  logic [CW-1:0] i_avg_x,
  input  logic [CW-1:0] i_avg_y,
  input  logic [CW-1:0] i_target_x,
  input  logic [CW-1:0] i_target_y,
  input  logic          i_disappear,
  output logic [AW-1:0] o_addr,
  output logic [15:0]   o_dout,
  output logic          o_we,
  output logic          o_frame_done,
  output logic          o_line_err
);

  localparam logic [CW-1:0] H_LIM  = CW'(H_RES);
  localparam logic [CW-1:0] V_LIM  = CW'(V_RES);
  localparam logic [AW-1:0] H_STEP = AW'(H_RES);

  state_e        r_state;
  logic          r_vsync_q, r_href_q;
  logic [CW-1:0] r_x, r_y;
  logic          r_phase;
  logic [7:0]    r_hi;
  // r_line_base tracks y*H_RES, r_pix_addr the address of the next pixel
  logic [AW-1:0] r_line_base, r_pix_addr;

  mode_e         r_mode;
  logic [CW-1:0] r_avg_x, r_avg_y, r_tgt_x, r_tgt_y;
  logic          r_disappear;

  logic [AW-1:0] r_addr;
  logic [15:0]   r_dout;
  logic          r_we, r_frame_done, r_line_err;

  logic [15:0]   w_raw, w_pix;
  logic [AW-1:0] w_next_base;
  logic          w_vs_rise, w_vs_fall, w_href_fall;

  assign w_raw       = {r_hi, i_d};
  assign w_next_base = r_line_base + H_STEP;
  assign w_vs_rise   = !r_vsync_q && i_vsync;
  assign w_vs_fall   = r_vsync_q && !i_vsync;
  assign w_href_fall = r_href_q && !i_href;

  ov_overlay_mux #(
    .CW       (CW),
    .MARK_R   (MARK_R),
    .TGT_SIZE (TGT_SIZE),
    .THRESH   (THRESH)
  ) u_mux (
    .i_x         (r_x),
    .i_y         (r_y),
    .i_mode      (r_mode),
    .i_avg_x     (r_avg_x),
    .i_avg_y     (r_avg_y),
    .i_target_x  (r_tgt_x),
    .i_target_y  (r_tgt_y),
    .i_disappear (r_disappear),
    .i_raw       (w_raw),
    .o_pix       (w_pix)
  );

  always_ff @(posedge i_pclk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state      <= StWaitSync;
      r_vsync_q    <= 1'b0;
      r_href_q     <= 1'b0;
      r_x          <= '0;
      r_y          <= '0;
      r_phase      <= 1'b0;
      r_hi         <= '0;
      r_line_base  <= '0;
      r_pix_addr   <= '0;
      r_mode       <= ModeRaw;
      r_avg_x      <= '0;
      r_avg_y      <= '0;
      r_tgt_x      <= '0;
      r_tgt_y      <= '0;
      r_disappear  <= 1'b0;
      r_addr       <= '0;
      r_dout       <= '0;
      r_we         <= 1'b0;
      r_frame_done <= 1'b0;
      r_line_err   <= 1'b0;
    end else begin
      r_vsync_q    <= i_vsync;
      r_href_q     <= i_href;
      r_we         <= 1'b0;
      r_frame_done <= 1'b0;

      unique case (r_state)
        // Drop whatever partial frame is in flight until blanking is seen.
        StWaitSync: begin
          if (i_vsync) r_state <= StBlank;
        end

        StBlank: begin
          r_x         <= '0;
          r_y         <= '0;
          r_phase     <= 1'b0;
          r_line_base <= '0;
          r_pix_addr  <= '0;
          if (w_vs_fall) begin
            r_mode      <= mode_e'(i_mode);
            r_avg_x     <= i_avg_x;
            r_avg_y     <= i_avg_y;
            r_tgt_x     <= i_target_x;
            r_tgt_y     <= i_target_y;
            r_disappear <= i_disappear;
            r_line_err  <= 1'b0;
            r_state     <= StActive;
          end
        end

        StActive: begin
          if (w_vs_rise) begin
            // Ends the frame even mid-line; a pixel completing now is dropped.
            r_frame_done <= (r_y != '0);
            r_state      <= StBlank;
          end else if (w_href_fall) begin
            // x saturates at H_RES, so only short lines are flagged.
            if (r_x != H_LIM) r_line_err <= 1'b1;
            if (r_y < V_LIM) begin
              r_y         <= r_y + CW'(1);
              r_line_base <= w_next_base;
            end
            r_pix_addr <= w_next_base;
            r_x        <= '0;
            r_phase    <= 1'b0;
          end else if (i_href) begin
            if (!r_phase) begin
              r_hi    <= i_d;
              r_phase <= 1'b1;
            end else begin
              r_phase <= 1'b0;
              if (r_x < H_LIM) begin
                r_x <= r_x + CW'(1);
                if (r_y < V_LIM) begin
                  r_we       <= 1'b1;
                  r_dout     <= w_pix;
                  r_addr     <= r_pix_addr;
                  r_pix_addr <= r_pix_addr + AW'(1);
                end
              end
            end
          end
        end

        default: r_state <= StWaitSync;
      endcase
    end
  end

  assign o_addr       = r_addr;
  assign o_dout       = r_dout;
  assign o_we         = r_we;
  assign o_frame_done = r_frame_done;
  assign o_line_err   = r_line_err;

endmodule

// File: tb/tb_ov_capture_overlay.sv
// Self-checking bench for ov_capture_overlay at a reduced 48x32 resolution.
// The driver knows every line it sends, so it computes each expected write
// (address, colour, cycle) from pixel coordinates and the frame-latched
// overlay settings; one compare process checks the outputs every cycle.
module tb_ov_capture_overlay;

  localparam int H  = 48;
  localparam int V  = 32;
  localparam int AW = 11;

  logic          clk;
  logic          resetn;
  logic          vsync, href;
  logic [7:0]    d;
  logic [1:0]    mode;
  logic [9:0]    avg_x, avg_y, target_x, target_y;
  logic          disappear;
  logic [AW-1:0] addr;
  logic [15:0]   dout;
  logic          we, frame_done, line_err;

  ov_capture_overlay #(
    .H_RES    (H),
    .V_RES    (V),
    .AW       (AW),
    .CW       (10),
    .MARK_R   (2),
    .TGT_SIZE (15),
    .THRESH   (12)
  ) dut (
    .i_pclk       (clk),
    .i_resetn     (resetn),
    .i_vsync      (vsync),
    .i_href       (href),
    .i_d          (d),
    .i_mode       (mode),
    .i_avg_x      (avg_x),
    .i_avg_y      (avg_y),
    .i_target_x   (target_x),
    .i_target_y   (target_y),
    .i_disappear  (disappear),
    .o_addr       (addr),
    .o_dout       (dout),
    .o_we         (we),
    .o_frame_done (frame_done),
    .o_line_err   (line_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;
  int n_wr   = 0;
  int n_fd   = 0;

  typedef struct {
    int          cyc;
    int          addr;
    logic [15:0] data;
  } wr_t;

  typedef struct {
    int   cyc;
    logic lerr;
  } fd_t;

  wr_t exp_q[$];
  fd_t fd_q[$];
  logic [15:0] fb [0:(1<<AW)-1];

  // Frame-latched overlay settings as the model sees them.
  int m_mode, m_ax, m_ay, m_tx, m_ty;
  bit m_dis;
  int pat;
  int lb [0:63];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] ref_pix(input int x, input int y, input logic [15:0] p);
    int dx, dy;
    dx = x - m_ax; if (dx < 0) dx = -dx;
    dy = y - m_ay; if (dy < 0) dy = -dy;
    if (m_mode == 0) return p;
    if (dx <= 2 && dy <= 2) return 16'h07E0;
    if (!m_dis && x >= m_tx && x < m_tx + 15 && y >= m_ty && y < m_ty + 15) return 16'hF800;
    if (m_mode == 2 && p[15:12] > 4'd12) return 16'h001F;
    return p;
  endfunction

  function automatic logic [15:0] gen_pix(input int ly, input int px);
    case (pat)
      0:       return 16'(ly * H + px);
      1:       return 16'(ly * H + px) ^ 16'h5A5A;
      3:       return (px % 2 == 0) ? 16'hF000 : 16'hC000;
      default: return 16'($urandom);
    endcase
  endfunction

  // Cycle-by-cycle comparison against the expected write / frame_done queues.
  initial begin : cmp
    wr_t e;
    fd_t f;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        n_chk++; n_fail++;
        if (n_fail <= 40) $display("FAIL missed_write: addr 0x%0h never written, due cycle %0d", e.addr, e.cyc);
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        chk("we", 32'(we), 32'd1);
        chk("addr", 32'(addr), 32'(e.addr));
        chk("dout", 32'(dout), 32'(e.data));
      end else begin
        chk("we_idle", 32'(we), 32'd0);
      end
      while (fd_q.size() > 0 && fd_q[0].cyc < cyc) begin
        f = fd_q.pop_front();
        n_chk++; n_fail++;
        if (n_fail <= 40) $display("FAIL missed_frame_done: due cycle %0d", f.cyc);
      end
      if (fd_q.size() > 0 && fd_q[0].cyc == cyc) begin
        f = fd_q.pop_front();
        chk("frame_done", 32'(frame_done), 32'd1);
        chk("line_err_at_done", 32'(line_err), 32'(f.lerr));
      end else begin
        chk("frame_done_idle", 32'(frame_done), 32'd0);
      end
      if (we === 1'b1) begin
        fb[addr] = dout;
        n_wr++;
      end
      if (frame_done === 1'b1) n_fd++;
    end
  end

  // One frame: blanking, vsync fall, nl lines of lb[] bytes, optional cut line
  // of cut_bytes bytes ended by vsync rising, optional mid-line reset, optional
  // avg_x change at the start of line chg_line.
  task automatic run_frame(input int nl, input int cut_bytes, input int rst_line,
                           input int chg_line, input int chg_ax);
    int          completed, nlines, nb, px;
    bit          live, lerr;
    logic [15:0] p;
    wr_t         e;
    fd_t         f;
    completed = 0; live = 1; lerr = 0; p = '0;
    href = 0; vsync = 1;
    repeat (6) step();
    m_mode = int'(mode); m_ax = int'(avg_x); m_ay = int'(avg_y);
    m_tx = int'(target_x); m_ty = int'(target_y); m_dis = disappear;
    vsync = 0;
    step();
    repeat (3) step();
    chk("line_err_clear", 32'(line_err), 32'd0);
    nlines = nl + ((cut_bytes > 0) ? 1 : 0);
    for (int ly = 0; ly < nlines; ly++) begin
      if (ly == chg_line) avg_x = 10'(chg_ax);
      nb = (ly < nl) ? lb[ly] : cut_bytes;
      for (int b = 0; b < nb; b++) begin
        px = b / 2;
        if (b % 2 == 0) p = gen_pix(ly, px);
        href = 1;
        d = (b % 2 == 0) ? p[15:8] : p[7:0];
        if (live && b % 2 == 1 && px < H && ly < V) begin
          e.cyc = cyc + 1; e.addr = ly * H + px; e.data = ref_pix(px, ly, p);
          exp_q.push_back(e);
        end
        step();
        if (ly == rst_line && b == 21) begin
          resetn = 0; live = 0;
          exp_q.delete(); fd_q.delete();
          #1;
          chk("rst_mid_we", 32'(we), 32'd0);
          chk("rst_mid_addr", 32'(addr), 32'd0);
          chk("rst_mid_dout", 32'(dout), 32'd0);
          chk("rst_mid_fd", 32'(frame_done), 32'd0);
          chk("rst_mid_lerr", 32'(line_err), 32'd0);
        end
        if (ly == rst_line && b == 25) resetn = 1;
      end
      if (ly < nl) begin
        href = 0;
        if (nb / 2 < H) lerr = 1;
        completed++;
        repeat (3) step();
      end
    end
    if (cut_bytes > 0) begin
      href = 1; d = 8'hA5;
    end
    vsync = 1;
    if (live && completed > 0) begin
      f.cyc = cyc + 1; f.lerr = lerr;
      fd_q.push_back(f);
    end
    step();
    href = 0;
    repeat (3) step();
    chk("queues_drained", 32'(exp_q.size() + fd_q.size()), 32'd0);
  endtask

  task automatic full_lines(input int nl);
    for (int i = 0; i < nl; i++) lb[i] = 2 * H;
  endtask

  initial begin : watchdog
    #(10 * 95000);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int w0, f0, nl, cut;
    resetn = 0; vsync = 0; href = 0; d = '0; mode = '0;
    avg_x = '0; avg_y = '0; target_x = '0; target_y = '0; disappear = 0;
    pat = 0;
    repeat (3) step();
    chk("reset_addr", 32'(addr), 32'd0);
    chk("reset_dout", 32'(dout), 32'd0);
    chk("reset_we", 32'(we), 32'd0);
    chk("reset_fd", 32'(frame_done), 32'd0);
    chk("reset_lerr", 32'(line_err), 32'd0);
    resetn = 1;

    // Partial frame after reset: must be discarded.
    for (int i = 0; i < 40; i++) begin
      href = (i % 20) < 16; d = 8'(i);
      step();
    end
    href = 0;

    // 1: raw mode, incrementing pixels.
    full_lines(V); mode = 2'd0; pat = 0;
    w0 = n_wr; f0 = n_fd;
    run_frame(V, 0, -1, -1, 0);
    chk("f1_write_count", 32'(n_wr - w0), 32'(H * V));
    chk("f1_frame_done_count", 32'(n_fd - f0), 32'd1);
    chk("f1_first", 32'(fb[0]), 32'h0000);
    chk("f1_mid", 32'(fb[777]), 32'h0309);
    chk("f1_last", 32'(fb[H * V - 1]), 32'h05FF);
    chk("f1_line_err", 32'(line_err), 32'd0);

    // 2: overlay mode, marker at (20,10), box at (5,8).
    mode = 2'd1; pat = 1; avg_x = 10'd20; avg_y = 10'd10;
    target_x = 10'd5; target_y = 10'd8; disappear = 0;
    run_frame(V, 0, -1, -1, 0);
    chk("f2_marker_centre", 32'(fb[500]), 32'h07E0);
    chk("f2_marker_corner", 32'(fb[598]), 32'h07E0);
    chk("f2_right_of_marker", 32'(fb[503]), 32'h5BAD);
    chk("f2_box_corner", 32'(fb[389]), 32'hF800);
    chk("f2_left_of_box", 32'(fb[388]), 32'h5BDE);
    chk("f2_marker_in_box", 32'(fb[403]), 32'h07E0);
    chk("f2_right_of_box", 32'(fb[980]), 32'h598E);
    chk("f2_box_bottom", 32'(fb[1075]), 32'hF800);
    chk("f2_below_box", 32'(fb[1123]), 32'h5E39);

    // 3: threshold mode.
    mode = 2'd2; pat = 3; avg_x = 10'd2; avg_y = 10'd2;
    target_x = 10'd3; target_y = 10'd3;
    run_frame(V, 0, -1, -1, 0);
    chk("f3_hot", 32'(fb[1480]), 32'h001F);
    chk("f3_at_thresh", 32'(fb[1481]), 32'hC000);

    // 4: one short and one long line.
    full_lines(V); lb[3] = 2 * H - 4; lb[5] = 2 * H + 4;
    mode = 2'd1; pat = 2;
    w0 = n_wr;
    run_frame(V, 0, -1, -1, 0);
    chk("f4_write_count", 32'(n_wr - w0), 32'(30 * H + (H - 2) + H));
    chk("f4_line_err_sticky", 32'(line_err), 32'd1);

    // 5/6: avg_x changed mid-frame applies only to the next frame.
    full_lines(V); mode = 2'd1; pat = 1;
    avg_x = 10'd20; avg_y = 10'd10; target_x = 10'd5; target_y = 10'd8;
    run_frame(V, 0, -1, 5, 30);
    chk("f5_old_marker", 32'(fb[500]), 32'h07E0);
    chk("f5_new_pos_raw", 32'(fb[510]), 32'h5BA4);
    run_frame(V, 0, -1, -1, 0);
    chk("f6_new_marker", 32'(fb[510]), 32'h07E0);
    chk("f6_old_pos_raw", 32'(fb[500]), 32'h5BAE);

    // 7: reset mid-line, then 8: a clean frame.
    pat = 2;
    run_frame(V, 0, 7, -1, 0);
    mode = 2'd0; pat = 0;
    w0 = n_wr; f0 = n_fd;
    run_frame(V, 0, -1, -1, 0);
    chk("f8_write_count", 32'(n_wr - w0), 32'(H * V));
    chk("f8_frame_done_count", 32'(n_fd - f0), 32'd1);
    chk("f8_last", 32'(fb[H * V - 1]), 32'h05FF);

    // Randomised frames: modes, overlays, odd/short/long lines, extra lines, cut frames.
    for (int k = 0; k < 5; k++) begin
      mode = 2'($urandom_range(0, 3));
      avg_x = 10'($urandom_range(0, H + 3));
      avg_y = 10'($urandom_range(0, V + 3));
      target_x = 10'($urandom_range(0, H));
      target_y = 10'($urandom_range(0, V));
      disappear = 1'($urandom_range(0, 1));
      pat = 2;
      case ($urandom_range(0, 2))
        0:       nl = V - 3;
        1:       nl = V;
        default: nl = V + 2;
      endcase
      for (int i = 0; i < nl; i++)
        lb[i] = ($urandom_range(0, 5) == 0) ? int'($urandom_range(2 * H - 7, 2 * H + 5)) : 2 * H;
      cut = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 2 * H)) : 0;
      run_frame(nl, cut, -1,
                ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, nl - 1)) : -1,
                int'($urandom_range(0, H)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ov_capture_overlay.md
Name: ov_capture_overlay

Overview:
Parametrised successor to the OV7670 capture stage. It assembles RGB565 pixels from the camera byte stream and writes them to the frame buffer. On the way it optionally overlays a laser-centroid marker, the game target box and a red-threshold highlight. Unlike the previous block it uses explicit x/y counters, a frame-sync state machine, frame-latched overlay inputs, a frame_done pulse and line-length error detection.

Parameters:
H_RES, 320, active pixels per line
V_RES, 240, active lines per frame
AW, 17, frame-buffer address width (must satisfy 2^AW >= H_RES*V_RES)
CW, 10, coordinate width for x/y ports and counters
MARK_R, 2, marker half-size; marker covers |dx|<=MARK_R and |dy|<=MARK_R
TGT_SIZE, 15, target box edge length in pixels
THRESH, 12, red threshold: pixel flagged when red[4:1] > THRESH

Ports:
pclk  in  1  camera pixel clock, the only clock
resetn  in  1  asynchronous active-low reset
vsync  in  1  camera vertical sync, high = blanking
href  in  1  camera line valid
d  in  8  camera data byte, high byte first
mode  in  2  0 raw, 1 overlay, 2 overlay+threshold, 3 treated as 1
avg_x, avg_y  in  CW each  laser centroid
target_x, target_y  in  CW each  target box top-left corner
disappear  in  1  1 = hide target box
addr  out  AW  frame-buffer write address
dout  out  16  RGB565 write data
we  out  1  write enable, one cycle per pixel
frame_done  out  1  one-cycle pulse at end of frame
line_err  out  1  sticky per frame: some line length != H_RES

Behaviour:
- Reset values: addr=0, dout=0, we=0, frame_done=0, line_err=0; x=y=0; byte phase=0; state=WAIT_SYNC.
- States:
  - WAIT_SYNC: discard data until vsync=1, then go to BLANK. This drops any partial frame after reset.
  - BLANK: hold x=y=0 and phase=0. On vsync 1->0:
    - latch mode, avg_x, avg_y, target_x, target_y and disappear for the frame;
    - clear line_err;
    - go to ACTIVE.
  - ACTIVE: capture the stream. On vsync 0->1: pulse frame_done for one cycle if y>0, then go to BLANK.
- Byte assembly in ACTIVE with href=1:
  - phase 0 latches the high byte;
  - phase 1 forms the pixel {hi,d} and toggles phase back to 0.
- Write timing:
  - the cycle after phase 1, if x<H_RES and y<V_RES: we=1, dout=overlay(pixel), addr=y*H_RES+x;
  - x then increments;
  - pixels with x>=H_RES or y>=V_RES are dropped (we=0) and x saturates at H_RES;
  - latency is exactly 1 pclk from the second byte to we.
- addr is kept as an incremental counter; no multiplier or divider.
- href 1->0:
  - set line_err if x != H_RES;
  - y increments, saturating at V_RES;
  - x=0 and phase=0, so a dangling odd byte is discarded.
- we is 0 on every cycle not listed above.
- Overlay priority, with coordinates compared in CW+1 bits so target+TGT_SIZE cannot overflow:
  1. marker → 0x07E0 (green);
  2. target box, tx<=x<tx+TGT_SIZE, ty<=y<ty+TGT_SIZE, disappear=0 → 0xF800 (red);
  3. mode 2 and red[4:1]>THRESH → 0x001F (blue);
  4. otherwise the raw pixel.
- Mode 0 bypasses all overlays.
- vsync rising mid-line: end the frame immediately; a pending pixel is dropped.
- resetn is asserted asynchronously at any time; capture resumes only after a full vsync high→low sequence.

Decomposition:
- Package ov_cap_pkg holds:
  - RGB565 colour constants (GREEN, RED, BLUE);
  - the mode encoding;
  - the state enum (WAIT_SYNC, BLANK, ACTIVE).
- Sub-module ov_overlay_mux: combinational pixel-colour decision from x, y, the latched overlay inputs and the raw pixel. The parent owns all registers.

Test Plan:
1. Reset, then a 320x240 frame in mode 0 with incrementing pixels → 76800 we pulses, addr 0..76799, dout equals the input pixels, frame_done pulses once, line_err=0.
2. Mode 1 with avg=(100,50) and target=(10,20), disappear=0 → addr 16100 gives 0x07E0, (102,52) green, (103,50) raw; addr 6410 (x=10,y=20) gives 0xF800, (25,20) raw; a marker inside the box gives green.
3. Mode 2, pixel 0xF000 outside both overlays → dout=0x001F; pixel 0xC000 (red[4:1]=12) → raw.
4. One line of 318 pixels and one line of 322 pixels → line_err=1 at frame_done; the long line writes only 320 pixels; line_err=0 after the next vsync falling edge.
5. avg_x changed mid-frame → the marker still uses the value latched at vsync falling; the new value applies next frame.
6. resetn pulsed mid-line → outputs return to 0 immediately; the remainder of that frame produces no we; the following full frame is captured normally.
